event_rate_meter: RTL and testbench

- Input-side companion to the divided-clock up/down LED counter.
- That counter generates a pulse stream at a selectable rate; this block reads an external pulse/event line and measures how many events arrive per fixed gate window.
- The result is latched onto the 8 LEDs once per window.
- Used to verify the divider/mux speed settings on the board, or to show the rate of an external sensor or button.

---
 rtl/event_rate_meter_if.sv | 14 +
 rtl/event_rate_meter.sv | 92 +++++++++
 tb/tb_event_rate_meter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_rate_meter_if.sv
// Bus bundle for event_rate_meter: control inputs, the event line and the latched result.
interface event_rate_meter_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [1:0]       edge_sel;
  logic             evt_in;
  logic [WIDTH-1:0] LED;
  logic             done;
  logic             ovf;

  modport master (output enable, edge_sel, evt_in, input LED, done, ovf);
  modport slave  (input enable, edge_sel, evt_in, output LED, done, ovf);
endinterface

// File: rtl/event_rate_meter.sv
// Counts qualified edges of an asynchronous event line over a fixed gate window
// and latches the saturated count onto LED once per window.
module event_rate_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int WIDTH       = 8
) (
  input  logic              clk,
  input  logic              reset,
  event_rate_meter_if.slave bus
);
  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] ACC_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1, r_sync2, r_prev;
  logic [GW-1:0]    r_gate;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_led;
  logic             r_sat, r_done, r_ovf;
  logic             w_rise, w_fall, w_ev, w_acc_full, w_terminal;
  logic [WIDTH-1:0] w_acc_inc;

  assign w_rise     = r_sync2 & ~r_prev;
  assign w_fall     = ~r_sync2 & r_prev;
  assign w_ev       = (bus.edge_sel == 2'b01) ? w_fall :
                      (bus.edge_sel == 2'b10) ? (w_rise | w_fall) : w_rise;
  assign w_acc_full = (r_acc == ACC_MAX);
  assign w_acc_inc  = (w_ev && !w_acc_full) ? r_acc + 1'b1 : r_acc;
  assign w_terminal = (r_state == MEASURE) && (r_gate == GATE_LAST);

  // Leaving MEASURE on a low enable covers both the mid-window abort and the
  // terminal cycle; the datapath decides whether the window is published.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.enable)  w_state_next = MEASURE;
      MEASURE: if (!bus.enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_gate  <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_led   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sync1 <= bus.evt_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_done  <= 1'b0;
      if (w_terminal) begin
        // The window completes even if enable drops in this very cycle.
        r_led  <= w_acc_inc;
        r_ovf  <= r_sat | (w_acc_full & w_ev);
        r_done <= 1'b1;
        r_gate <= '0;
        r_acc  <= '0;
        r_sat  <= 1'b0;
      end else if (r_state == IDLE || !bus.enable) begin
        r_gate <= '0;
        r_acc  <= '0;
        r_sat  <= 1'b0;
      end else begin
        r_gate <= r_gate + 1'b1;
        r_acc  <= w_acc_inc;
        r_sat  <= r_sat | (w_acc_full & w_ev);
      end
    end
  end

  assign bus.LED  = r_led;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_event_rate_meter.sv
// Bench for event_rate_meter: a 16-cycle and a 300-cycle instance checked every cycle
// against a window-level reference model, plus directed vectors and corner sequences.
module tb_event_rate_meter;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic       manual_evt;
  int         wave_half;
  int         wave_cnt;
  logic       wave_bit;
  logic       evt;
  int         n_cmp;
  int         n_bad;
  bit         started;

  event_rate_meter_if #(.WIDTH(8)) b16 ();
  event_rate_meter_if #(.WIDTH(8)) b300 ();

  assign evt           = (wave_half != 0) ? wave_bit : manual_evt;
  assign b16.enable    = en;
  assign b16.edge_sel  = sel;
  assign b16.evt_in    = evt;
  assign b300.enable   = en;
  assign b300.edge_sel = sel;
  assign b300.evt_in   = evt;

  event_rate_meter #(.GATE_CYCLES(16), .WIDTH(8)) dut16 (
    .clk(clk), .reset(rst_n), .bus(b16.slave));
  event_rate_meter #(.GATE_CYCLES(300), .WIDTH(8)) dut300 (
    .clk(clk), .reset(rst_n), .bus(b300.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square-wave source: toggles every wave_half cycles; wave_half==0 hands evt to manual_evt.
  always @(negedge clk) begin
    if (wave_half == 0) begin
      wave_cnt <= 0;
      wave_bit <= 1'b0;
    end else if (wave_cnt + 1 >= wave_half) begin
      wave_cnt <= 0;
      wave_bit <= ~wave_bit;
    end else begin
      wave_cnt <= wave_cnt + 1;
    end
  end

  // Reference model: remembers the last three sampled levels of the event line and
  // counts qualified edges per window as an unbounded integer, clipped only when published.
  typedef struct {
    bit d1, d2, d3;
    bit meas;
    int phase;
    int cnt;
    int led;
    bit ovf;
    bit done;
  } mdl_t;

  function automatic mdl_t step(mdl_t m, int gate, bit r, bit e, bit [1:0] s, bit x);
    mdl_t n = m;
    bit rise, fall, ev;
    if (!r) begin
      n = '{default: 0};
      return n;
    end
    rise = m.d2 && !m.d3;
    fall = !m.d2 && m.d3;
    ev   = (s == 2'b01) ? fall : (s == 2'b10) ? (rise || fall) : rise;
    n.d3 = m.d2;
    n.d2 = m.d1;
    n.d1 = x;
    n.done = 1'b0;
    if (!m.meas) begin
      n.meas  = e;
      n.phase = 0;
      n.cnt   = 0;
    end else if (m.phase == gate - 1) begin
      n.led   = (m.cnt + int'(ev) > 255) ? 255 : m.cnt + int'(ev);
      n.ovf   = (m.cnt + int'(ev) > 255);
      n.done  = 1'b1;
      n.cnt   = 0;
      n.phase = 0;
      n.meas  = e;
    end else if (!e) begin
      n.meas  = 1'b0;
      n.cnt   = 0;
      n.phase = 0;
    end else begin
      n.cnt   = m.cnt + int'(ev);
      n.phase = m.phase + 1;
    end
    return n;
  endfunction

  mdl_t m16, m300;

  always @(posedge clk) begin
    m16     <= step(m16, 16, rst_n, en, sel, evt);
    m300    <= step(m300, 300, rst_n, en, sel, evt);
    started <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous scoreboard: {LED, done, ovf} of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      check("model16",  32'({b16.LED, b16.done, b16.ovf}),
                        32'({8'(m16.led), m16.done, m16.ovf}));
      check("model300", 32'({b300.LED, b300.done, b300.ovf}),
                        32'({8'(m300.led), m300.done, m300.ovf}));
    end
  end

  task automatic wait_done(input bit big, input int budget, output int waited);
    logic d;
    waited = 0;
    d      = 1'b0;
    while (!d && waited < budget) begin
      @(negedge clk);
      waited++;
      d = big ? b300.done : b16.done;
    end
    check(big ? "done300_arrived" : "done16_arrived", 32'(d), 32'd1);
  endtask

  typedef struct {
    logic [1:0] sel;
    int         half;
    int         led;
    bit         ovf;
  } vec_t;

  vec_t vecs[6];
  int   w;
  int   n_done;
  int   dens;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    started    = 1'b0;
    rst_n      = 1'b0;
    en         = 1'b0;
    sel        = 2'b00;
    manual_evt = 1'b0;
    wave_half  = 1;
    dens       = 50;

    vecs[0] = '{sel: 2'b00, half: 2, led: 4, ovf: 1'b0};
    vecs[1] = '{sel: 2'b10, half: 2, led: 8, ovf: 1'b0};
    vecs[2] = '{sel: 2'b01, half: 2, led: 4, ovf: 1'b0};
    vecs[3] = '{sel: 2'b11, half: 2, led: 4, ovf: 1'b0};
    vecs[4] = '{sel: 2'b00, half: 4, led: 2, ovf: 1'b0};
    vecs[5] = '{sel: 2'b10, half: 4, led: 4, ovf: 1'b0};

    // Reset with a busy event line, then idle with enable low.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({b16.LED, b16.done, b16.ovf}), 32'd0);
    rst_n     = 1'b1;
    wave_half = 0;
    n_done    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b16.done) n_done++;
    end
    check("idle_no_done", 32'(n_done), 32'd0);
    check("idle_led", 32'(b16.LED), 32'd0);

    // Phase-locked square waves: skip the first window, check the next two and their spacing.
    foreach (vecs[i]) begin
      en = 1'b0;
      repeat (3) @(negedge clk);
      sel       = vecs[i].sel;
      wave_half = vecs[i].half;
      en        = 1'b1;
      wait_done(1'b0, 40, w);
      wait_done(1'b0, 20, w);
      check("vec_led", 32'(b16.LED), 32'(vecs[i].led));
      check("vec_ovf", 32'(b16.ovf), 32'(vecs[i].ovf));
      wait_done(1'b0, 20, w);
      check("vec_period", 32'(w), 32'd16);
      check("vec_led_again", 32'(b16.LED), 32'(vecs[i].led));
    end

    // Saturation on the 300-cycle instance, then a quiet line.
    en = 1'b0;
    repeat (3) @(negedge clk);
    sel       = 2'b10;
    wave_half = 1;
    en        = 1'b1;
    wait_done(1'b1, 320, w);
    check("sat_led", 32'(b300.LED), 32'd255);
    check("sat_ovf", 32'(b300.ovf), 32'd1);
    wave_half  = 0;
    manual_evt = 1'b0;
    wait_done(1'b1, 320, w);
    wait_done(1'b1, 320, w);
    check("quiet_led", 32'(b300.LED), 32'd0);
    check("quiet_ovf", 32'(b300.ovf), 32'd0);

    // Enable dropped at cycle 7 of a window: partial count is discarded.
    sel       = 2'b10;
    wave_half = 2;
    wait_done(1'b0, 20, w);
    wait_done(1'b0, 20, w);
    check("pre_abort_led", 32'(b16.LED), 32'd8);
    sel = 2'b00;
    repeat (7) @(negedge clk);
    en     = 1'b0;
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (b16.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_led_held", 32'(b16.LED), 32'd8);
    en = 1'b1;
    wait_done(1'b0, 20, w);
    check("restart_led", 32'(b16.LED), 32'd4);

    // Single pulse whose rise is accumulated in the terminal cycle.
    wave_half  = 0;
    manual_evt = 1'b0;
    repeat (40) @(negedge clk);
    wait_done(1'b0, 20, w);
    repeat (13) @(negedge clk);
    manual_evt = 1'b1;
    repeat (2) @(negedge clk);
    manual_evt = 1'b0;
    wait_done(1'b0, 20, w);
    check("terminal_pulse_led", 32'(b16.LED), 32'd1);
    wait_done(1'b0, 20, w);
    check("after_pulse_led", 32'(b16.LED), 32'd0);

    // Enable dropped in the terminal cycle: that window is still published.
    wave_half = 2;
    wait_done(1'b0, 20, w);
    wait_done(1'b0, 20, w);
    repeat (15) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("term_drop_done", 32'(b16.done), 32'd1);
    check("term_drop_led", 32'(b16.LED), 32'd4);
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (b16.done) n_done++;
    end
    check("term_drop_idle", 32'(n_done), 32'd0);

    // Random traffic, enable toggles and occasional resets, checked by the scoreboard.
    wave_half = 0;
    en        = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      manual_evt = ($urandom_range(0, 99) < dens);
      if ($urandom_range(0, 49) == 0) begin
        sel  = 2'($urandom_range(0, 3));
        dens = $urandom_range(5, 95);
      end
      if ($urandom_range(0, 99) == 0) en = ~en;
      rst_n = ($urandom_range(0, 799) != 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
